id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and operand-forwarding stage of the RV32IM pipeline; feeds DATA1/DATA2/SELECT of alu.
//  Registers decoded fields, resolves RAW hazards from EX/MEM and MEM/WB, and applies PC/imm operand selection.
//  Honours stall (hold) and flush (bubble) from the hazard unit; keeps held operands fresh during stalls.
// PARAMETERS
//  XLEN      32   datapath width
//  RESET_PC  0    EX_PC value after reset
// PORTS
//  CLK             in   1     clock, rising edge
//  RESET           in   1     asynchronous, active-low reset
//  STALL           in   1     1 = hold stage contents
//  FLUSH           in   1     1 = load bubble next edge (wins over STALL)
//  ID_VALID        in   1     ID-stage instruction valid
//  ID_PC           in   XLEN  PC of ID instruction
//  ID_RS1_DATA     in   XLEN  register-file read 1
//  ID_RS2_DATA     in   XLEN  register-file read 2
//  ID_IMM          in   XLEN  sign-extended immediate
//  ID_RS1_ADDR     in   5     source register 1 index
//  ID_RS2_ADDR     in   5     source register 2 index
//  ID_RD_ADDR      in   5     destination register index
//  ID_ALU_SELECT   in   5     alu opcode (alu SELECT encoding)
//  ID_OP1_SEL      in   1     0 = rs1, 1 = PC
//  ID_OP2_SEL      in   1     0 = rs2, 1 = imm
//  ID_REG_WRITE    in   1     instruction writes rd
//  EXMEM_RD_ADDR   in   5     EX/MEM destination
//  EXMEM_REG_WRITE in   1     EX/MEM writes rd
//  EXMEM_RESULT    in   XLEN  EX/MEM result
//  MEMWB_RD_ADDR   in   5     MEM/WB destination
//  MEMWB_REG_WRITE in   1     MEM/WB writes rd
//  MEMWB_RESULT    in   XLEN  MEM/WB writeback value
//  DATA1           out  XLEN  alu operand 1
//  DATA2           out  XLEN  alu operand 2
//  SELECT          out  5     alu opcode
//  EX_RS2_FWD      out  XLEN  forwarded rs2 (store data)
//  EX_PC           out  XLEN  registered PC
//  EX_RD_ADDR      out  5     registered rd
//  EX_REG_WRITE    out  1     registered write enable, gated by EX_VALID
//  EX_VALID        out  1     stage holds a live instruction
// BEHAVIOUR
//  - Reset (RESET=0, async): all registers 0, EX_PC=RESET_PC, EX_VALID=0; outputs DATA1=DATA2=0, SELECT=0.
//  - Latency 1 cycle: ID inputs captured on rising CLK; DATA1/DATA2 combinational from regs + forward muxes.
//  - Edge priority: FLUSH > STALL > load. FLUSH: EX_VALID=0, EX_REG_WRITE=0, rd=0, SELECT=0 (ADD), rs addr=0.
//  - STALL (no FLUSH): all control fields held; rs1/rs2 data regs reloaded with their forwarded values, so
//    producers leaving EX/MEM or MEM/WB during stall are not lost.
//  - Load (neither): all fields from ID; EX_VALID <= ID_VALID; invalid instr forces REG_WRITE reg to 0.
//  - Forward rsN (N=1,2), per registered rsN_addr: if EXMEM_REG_WRITE && EXMEM_RD_ADDR==rsN && rsN!=0 ->
//    EXMEM_RESULT; else if MEMWB_REG_WRITE && MEMWB_RD_ADDR==rsN && rsN!=0 -> MEMWB_RESULT; else reg data.
//    EX/MEM wins when both match. x0 never forwarded; rs reading x0 yields 0 regardless of reg data.
//  - DATA1 = OP1_SEL ? EX_PC : fwd_rs1.  DATA2 = OP2_SEL ? EX_IMM : fwd_rs2.  EX_RS2_FWD = fwd_rs2 always.
//  - When EX_VALID=0, DATA1/DATA2 still driven (don't-care) but EX_REG_WRITE=0.
//  - Reset asserted mid-stall/mid-flush: immediate clear; first edge after release loads normally.
// TESTING
//  1 Reset: RESET=0 while inputs busy -> EX_VALID=0, DATA1=DATA2=0, SELECT=0, EX_PC=RESET_PC.
//  2 Load: rs1=10, rs2=5, SELECT=5'b00000, no matches -> next cycle DATA1=10, DATA2=5, EX_VALID=1.
//  3 Forward: rs1_addr=3, EXMEM rd=3 wr=1 res=0x55, MEMWB rd=3 res=0x66 -> DATA1=0x55; EXMEM wr=0 -> 0x66.
//  4 x0: rs1_addr=0, EXMEM rd=0 wr=1 res=0xDEAD -> DATA1=0 (not forwarded).
//  5 Stall: STALL=1 3 cycles, MEMWB rd=rs2 res=0x77 for 1 cycle then drops -> DATA2 stays 0x77, SELECT held.
//  6 Flush vs stall: FLUSH=1,STALL=1 same edge -> EX_VALID=0, EX_REG_WRITE=0, SELECT=0; OP2_SEL=1 imm=-4 -> DATA2=0xFFFFFFFC.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: decoded ID fields, hazard controls, forwarding sources and ALU-facing results.
interface id_ex_operand_stage_if #(
   parameter int unsigned XLEN = 32
);
   localparam int unsigned RW = 5;

   logic            STALL;
   logic            FLUSH;
   logic            ID_VALID;
   logic [XLEN-1:0] ID_PC;
   logic [XLEN-1:0] ID_RS1_DATA;
   logic [XLEN-1:0] ID_RS2_DATA;
   logic [XLEN-1:0] ID_IMM;
   logic [RW-1:0]   ID_RS1_ADDR;
   logic [RW-1:0]   ID_RS2_ADDR;
   logic [RW-1:0]   ID_RD_ADDR;
   logic [RW-1:0]   ID_ALU_SELECT;
   logic            ID_OP1_SEL;
   logic            ID_OP2_SEL;
   logic            ID_REG_WRITE;
   logic [RW-1:0]   EXMEM_RD_ADDR;
   logic            EXMEM_REG_WRITE;
   logic [XLEN-1:0] EXMEM_RESULT;
   logic [RW-1:0]   MEMWB_RD_ADDR;
   logic            MEMWB_REG_WRITE;
   logic [XLEN-1:0] MEMWB_RESULT;
   logic [XLEN-1:0] DATA1;
   logic [XLEN-1:0] DATA2;
   logic [RW-1:0]   SELECT;
   logic [XLEN-1:0] EX_RS2_FWD;
   logic [XLEN-1:0] EX_PC;
   logic [RW-1:0]   EX_RD_ADDR;
   logic            EX_REG_WRITE;
   logic            EX_VALID;

   // Pipeline side: decode/hazard/forwarding producers, ALU consumer
   modport master (
      output STALL, FLUSH, ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
             ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_ALU_SELECT, ID_OP1_SEL,
             ID_OP2_SEL, ID_REG_WRITE, EXMEM_RD_ADDR, EXMEM_REG_WRITE, EXMEM_RESULT,
             MEMWB_RD_ADDR, MEMWB_REG_WRITE, MEMWB_RESULT,
      input  DATA1, DATA2, SELECT, EX_RS2_FWD, EX_PC, EX_RD_ADDR, EX_REG_WRITE, EX_VALID
   );

   // Stage side
   modport slave (
      input  STALL, FLUSH, ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
             ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_ALU_SELECT, ID_OP1_SEL,
             ID_OP2_SEL, ID_REG_WRITE, EXMEM_RD_ADDR, EXMEM_REG_WRITE, EXMEM_RESULT,
             MEMWB_RD_ADDR, MEMWB_REG_WRITE, MEMWB_RESULT,
      output DATA1, DATA2, SELECT, EX_RS2_FWD, EX_PC, EX_RD_ADDR, EX_REG_WRITE, EX_VALID
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and PC/imm operand selection.
module id_ex_operand_stage #(
   parameter int unsigned    XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                 CLK,
   input  logic                 RESET,
   id_ex_operand_stage_if.slave bus
);
   localparam int unsigned RW = 5;

   logic            valid_q,     valid_d;
   logic            reg_write_q, reg_write_d;
   logic [XLEN-1:0] pc_q,        pc_d;
   logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
   logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
   logic [XLEN-1:0] imm_q,       imm_d;
   logic [RW-1:0]   rs1_addr_q,  rs1_addr_d;
   logic [RW-1:0]   rs2_addr_q,  rs2_addr_d;
   logic [RW-1:0]   rd_addr_q,   rd_addr_d;
   logic [RW-1:0]   select_q,    select_d;
   logic            op1_sel_q,   op1_sel_d;
   logic            op2_sel_q,   op2_sel_d;

   logic [XLEN-1:0] fwd_rs1_c;
   logic [XLEN-1:0] fwd_rs2_c;

   // Forward muxes: EX/MEM beats MEM/WB; x0 always reads as zero
   always_comb begin
      fwd_rs1_c = rs1_data_q;
      if (rs1_addr_q == RW'(0))
         fwd_rs1_c = '0;
      else if (bus.EXMEM_REG_WRITE && (bus.EXMEM_RD_ADDR == rs1_addr_q))
         fwd_rs1_c = bus.EXMEM_RESULT;
      else if (bus.MEMWB_REG_WRITE && (bus.MEMWB_RD_ADDR == rs1_addr_q))
         fwd_rs1_c = bus.MEMWB_RESULT;

      fwd_rs2_c = rs2_data_q;
      if (rs2_addr_q == RW'(0))
         fwd_rs2_c = '0;
      else if (bus.EXMEM_REG_WRITE && (bus.EXMEM_RD_ADDR == rs2_addr_q))
         fwd_rs2_c = bus.EXMEM_RESULT;
      else if (bus.MEMWB_REG_WRITE && (bus.MEMWB_RD_ADDR == rs2_addr_q))
         fwd_rs2_c = bus.MEMWB_RESULT;
   end

   // Next-state: flush inserts a bubble, stall holds control but refreshes operands, otherwise load from ID
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      pc_d        = pc_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_addr_d   = rd_addr_q;
      select_d    = select_q;
      op1_sel_d   = op1_sel_q;
      op2_sel_d   = op2_sel_q;

      if (bus.FLUSH) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         rd_addr_d   = '0;
         select_d    = '0;
         rs1_addr_d  = '0;
         rs2_addr_d  = '0;
         // Datapath fields of a bubble are don't-care; take them from ID
         pc_d        = bus.ID_PC;
         imm_d       = bus.ID_IMM;
         rs1_data_d  = bus.ID_RS1_DATA;
         rs2_data_d  = bus.ID_RS2_DATA;
         op1_sel_d   = bus.ID_OP1_SEL;
         op2_sel_d   = bus.ID_OP2_SEL;
      end else if (bus.STALL) begin
         // Capture producers that may retire while we are held
         rs1_data_d  = fwd_rs1_c;
         rs2_data_d  = fwd_rs2_c;
      end else begin
         valid_d     = bus.ID_VALID;
         reg_write_d = bus.ID_REG_WRITE & bus.ID_VALID;
         pc_d        = bus.ID_PC;
         rs1_data_d  = bus.ID_RS1_DATA;
         rs2_data_d  = bus.ID_RS2_DATA;
         imm_d       = bus.ID_IMM;
         rs1_addr_d  = bus.ID_RS1_ADDR;
         rs2_addr_d  = bus.ID_RS2_ADDR;
         rd_addr_d   = bus.ID_RD_ADDR;
         select_d    = bus.ID_ALU_SELECT;
         op1_sel_d   = bus.ID_OP1_SEL;
         op2_sel_d   = bus.ID_OP2_SEL;
      end
   end

   // Stage registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         pc_q        <= RESET_PC;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_addr_q   <= '0;
         select_q    <= '0;
         op1_sel_q   <= 1'b0;
         op2_sel_q   <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         pc_q        <= pc_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_addr_q   <= rd_addr_d;
         select_q    <= select_d;
         op1_sel_q   <= op1_sel_d;
         op2_sel_q   <= op2_sel_d;
      end
   end

   // ALU operands and EX-stage outputs
   assign bus.DATA1        = op1_sel_q ? pc_q  : fwd_rs1_c;
   assign bus.DATA2        = op2_sel_q ? imm_q : fwd_rs2_c;
   assign bus.EX_RS2_FWD   = fwd_rs2_c;
   assign bus.SELECT       = select_q;
   assign bus.EX_PC        = pc_q;
   assign bus.EX_RD_ADDR   = rd_addr_q;
   assign bus.EX_REG_WRITE = reg_write_q & valid_q;
   assign bus.EX_VALID     = valid_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;
   localparam int unsigned    XLEN     = 32;
   localparam logic [31:0]    RST_PC   = 32'h0000_0100;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] fwd2;
      logic [31:0] pc;
      logic [4:0]  sel;
      logic [4:0]  rd;
      logic        v;
      logic        rw;
   } exp_t;

   logic CLK;
   logic RESET;
   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   id_ex_operand_stage_if #(.XLEN(XLEN)) bus ();

   id_ex_operand_stage #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1a,
                         input logic [31:0] rs1d, input logic [4:0] rs2a, input logic [31:0] rs2d,
                         input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] sel,
                         input logic op1, input logic op2, input logic rw);
      bus.ID_VALID      = v;
      bus.ID_PC         = pc;
      bus.ID_RS1_ADDR   = rs1a;
      bus.ID_RS1_DATA   = rs1d;
      bus.ID_RS2_ADDR   = rs2a;
      bus.ID_RS2_DATA   = rs2d;
      bus.ID_IMM        = imm;
      bus.ID_RD_ADDR    = rd;
      bus.ID_ALU_SELECT = sel;
      bus.ID_OP1_SEL    = op1;
      bus.ID_OP2_SEL    = op2;
      bus.ID_REG_WRITE  = rw;
   endtask

   task automatic set_fwd(input logic [4:0] exrd, input logic exwr, input logic [31:0] exres,
                          input logic [4:0] mwrd, input logic mwwr, input logic [31:0] mwres);
      bus.EXMEM_RD_ADDR   = exrd;
      bus.EXMEM_REG_WRITE = exwr;
      bus.EXMEM_RESULT    = exres;
      bus.MEMWB_RD_ADDR   = mwrd;
      bus.MEMWB_REG_WRITE = mwwr;
      bus.MEMWB_RESULT    = mwres;
   endtask

   task automatic push(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] fwd2,
                       input logic [31:0] pc, input logic [4:0] sel, input logic [4:0] rd,
                       input logic v, input logic rw);
      exp_t e;
      e.d1 = d1; e.d2 = d2; e.fwd2 = fwd2; e.pc = pc;
      e.sel = sel; e.rd = rd; e.v = v; e.rw = rw;
      sb.push_back(e);
   endtask

   task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
      end
   endtask

   task automatic check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_fail++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         cmp(tag, "DATA1",      bus.DATA1,                e.d1);
         cmp(tag, "DATA2",      bus.DATA2,                e.d2);
         cmp(tag, "EX_RS2_FWD", bus.EX_RS2_FWD,           e.fwd2);
         cmp(tag, "EX_PC",      bus.EX_PC,                e.pc);
         cmp(tag, "SELECT",     32'(bus.SELECT),          32'(e.sel));
         cmp(tag, "EX_RD_ADDR", 32'(bus.EX_RD_ADDR),      32'(e.rd));
         cmp(tag, "EX_VALID",   32'(bus.EX_VALID),        32'(e.v));
         cmp(tag, "EX_REG_WRITE", 32'(bus.EX_REG_WRITE),  32'(e.rw));
      end
   endtask

   initial begin
      CLK       = 1'b0;
      RESET     = 1'b0;
      bus.STALL = 1'b0;
      bus.FLUSH = 1'b0;
      set_fwd(5'd1, 1'b1, 32'hAAAA_AAAA, 5'd2, 1'b1, 32'hBBBB_BBBB);
      set_id(1'b1, 32'h0000_0F00, 5'd1, 32'h1111, 5'd2, 32'h2222, 32'h3333, 5'd9, 5'd6, 1'b1, 1'b1, 1'b1);

      // Reset while inputs are busy
      push(32'h0, 32'h0, 32'h0, RST_PC, 5'd0, 5'd0, 1'b0, 1'b0);
      step(); step();
      check("reset");

      // Plain load, no forwarding
      RESET = 1'b1;
      set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      set_id(1'b1, 32'h0000_1000, 5'd1, 32'd10, 5'd2, 32'd5, 32'h0, 5'd4, 5'b00000, 1'b0, 1'b0, 1'b1);
      push(32'd10, 32'd5, 32'd5, 32'h0000_1000, 5'd0, 5'd4, 1'b1, 1'b1);
      step();
      check("load");

      // Forwarding priority on rs1 and MEM/WB forward on rs2
      set_id(1'b1, 32'h0000_1004, 5'd3, 32'h11, 5'd6, 32'h22, 32'h0, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1);
      step();
      set_fwd(5'd3, 1'b1, 32'h55, 5'd3, 1'b1, 32'h66);
      #1;
      push(32'h55, 32'h22, 32'h22, 32'h0000_1004, 5'd3, 5'd7, 1'b1, 1'b1);
      check("fwd_exmem_wins");
      bus.EXMEM_REG_WRITE = 1'b0;
      #1;
      push(32'h66, 32'h22, 32'h22, 32'h0000_1004, 5'd3, 5'd7, 1'b1, 1'b1);
      check("fwd_memwb");
      set_fwd(5'd0, 1'b0, 32'h0, 5'd6, 1'b1, 32'h6060);
      #1;
      push(32'h11, 32'h6060, 32'h6060, 32'h0000_1004, 5'd3, 5'd7, 1'b1, 1'b1);
      check("fwd_rs2_memwb");

      // x0 source is never forwarded and reads zero
      set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      set_id(1'b1, 32'h0000_1008, 5'd0, 32'h1234, 5'd2, 32'h8, 32'h0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b1);
      step();
      set_fwd(5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF);
      #1;
      push(32'h0, 32'h8, 32'h8, 32'h0000_1008, 5'd1, 5'd5, 1'b1, 1'b1);
      check("x0");

      // Invalid instruction never writes
      set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      set_id(1'b0, 32'h0000_100C, 5'd1, 32'h3, 5'd2, 32'h4, 32'h0, 5'd8, 5'd2, 1'b0, 1'b0, 1'b1);
      push(32'h3, 32'h4, 32'h4, 32'h0000_100C, 5'd2, 5'd8, 1'b0, 1'b0);
      step();
      check("invalid");

      // Stall: MEM/WB producer of rs2 retires during the first stalled cycle
      set_id(1'b1, 32'h0000_1010, 5'd1, 32'h44, 5'd9, 32'h33, 32'h0, 5'd10, 5'd7, 1'b0, 1'b0, 1'b1);
      step();
      bus.STALL = 1'b1;
      set_id(1'b1, 32'h0000_2222, 5'd4, 32'h99, 5'd5, 32'h98, 32'h7, 5'd11, 5'd2, 1'b1, 1'b1, 1'b0);
      set_fwd(5'd0, 1'b0, 32'h0, 5'd9, 1'b1, 32'h77);
      #1;
      push(32'h44, 32'h77, 32'h77, 32'h0000_1010, 5'd7, 5'd10, 1'b1, 1'b1);
      check("stall_c0");
      for (int i = 1; i <= 3; i++) begin
         step();
         if (i == 1) bus.MEMWB_REG_WRITE = 1'b0;
         #1;
         push(32'h44, 32'h77, 32'h77, 32'h0000_1010, 5'd7, 5'd10, 1'b1, 1'b1);
         check($sformatf("stall_c%0d", i));
      end
      bus.STALL = 1'b0;

      // PC/imm operand selection
      set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      set_id(1'b1, 32'h0000_2000, 5'd1, 32'h1, 5'd2, 32'h5, 32'hFFFF_FFFC, 5'd12, 5'd5, 1'b1, 1'b1, 1'b1);
      push(32'h0000_2000, 32'hFFFF_FFFC, 32'h5, 32'h0000_2000, 5'd5, 5'd12, 1'b1, 1'b1);
      step();
      check("pc_imm");

      // Flush wins over stall
      bus.FLUSH = 1'b1;
      bus.STALL = 1'b1;
      push(32'h0000_2000, 32'hFFFF_FFFC, 32'h0, 32'h0000_2000, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      check("flush_vs_stall");
      bus.FLUSH = 1'b0;

      // Async reset in the middle of a stall, then a normal load
      set_id(1'b1, 32'h0000_2004, 5'd1, 32'h1, 5'd2, 32'h2, 32'h3, 5'd13, 5'd9, 1'b0, 1'b0, 1'b1);
      step();
      #2;
      RESET = 1'b0;
      #1;
      push(32'h0, 32'h0, 32'h0, RST_PC, 5'd0, 5'd0, 1'b0, 1'b0);
      check("reset_mid_stall");
      step();
      RESET     = 1'b1;
      bus.STALL = 1'b0;
      set_id(1'b1, 32'h0000_3000, 5'd1, 32'hA, 5'd2, 32'hB, 32'h0, 5'd1, 5'd4, 1'b0, 1'b0, 1'b1);
      push(32'hA, 32'hB, 32'hB, 32'h0000_3000, 5'd4, 5'd1, 1'b1, 1'b1);
      step();
      check("load_after_reset");

      if (sb.size() != 0) begin
         n_vec++;
         n_fail++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
